pcileech_bar_rd_initiator: RTL

- Requester-side engine for the BAR access interface. Converts a simple command stream (read/write, addr, be, data, tag) into wr_* pulses and rd_req_* requests toward one BAR responder.
- Matches rd_rsp_* replies against the outstanding request and returns data with a tag.
- Detects a missing reply by timeout and completes the read with an error flag.
- Used by bench and debug logic to drive BAR implementations, e.g. fake NIC register files, from a command source.

---
 rtl/pcileech_bar_rd_initiator_if.sv | 52 +++++
 rtl/pcileech_bar_rd_initiator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pcileech_bar_rd_initiator_if.sv
// Command / BAR-access / result bundle for pcileech_bar_rd_initiator.
// The master modport is the initiator side; slave is the command source and BAR responder.
interface pcileech_bar_rd_initiator_if #(
  parameter int TAG_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [31:0]      cmd_addr;
  logic [3:0]       cmd_be;
  logic [31:0]      cmd_wdata;
  logic [TAG_W-1:0] cmd_tag;

  logic [31:0]      wr_addr;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic             wr_valid;

  logic [87:0]      rd_req_ctx;
  logic [31:0]      rd_req_addr;
  logic             rd_req_valid;

  logic [87:0]      rd_rsp_ctx;
  logic [31:0]      rd_rsp_data;
  logic             rd_rsp_valid;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_be, cmd_wdata, cmd_tag,
    output cmd_ready,
    output wr_addr, wr_be, wr_data, wr_valid,
    output rd_req_ctx, rd_req_addr, rd_req_valid,
    input  rd_rsp_ctx, rd_rsp_data, rd_rsp_valid,
    output res_valid, res_data, res_tag, res_err,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_be, cmd_wdata, cmd_tag,
    input  cmd_ready,
    input  wr_addr, wr_be, wr_data, wr_valid,
    input  rd_req_ctx, rd_req_addr, rd_req_valid,
    output rd_rsp_ctx, rd_rsp_data, rd_rsp_valid,
    input  res_valid, res_data, res_tag, res_err,
    output res_ready
  );
endinterface

// File: rtl/pcileech_bar_rd_initiator.sv
// BAR access requester: one command in flight, posted writes, tagged reads with timeout.
// Optional statistics counters are enabled by defining BAR_RD_INITIATOR_STATS_EN.
module pcileech_bar_rd_initiator #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TAG_W          = 8
) (
  input  logic clk,
  input  logic rst,
  pcileech_bar_rd_initiator_if.master bus
`ifdef BAR_RD_INITIATOR_STATS_EN
  ,
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
  output logic [15:0] stat_timeout_cnt,
  output logic [15:0] stat_drop_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [7:0]       seq_q, seq_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      wr_addr_q, wr_data_q, rd_req_addr_q, res_data_q;
  logic [3:0]       wr_be_q;
  logic [87:0]      rd_req_ctx_q;
  logic             wr_valid_q, rd_req_valid_q, res_valid_q, res_err_q;
  logic [TAG_W-1:0] res_tag_q;

  logic [7:0]       tag8;
  logic [31:0]      addr_aligned;
  logic             rsp_match, timeout_hit;
  logic             unused_bits;

  assign tag8         = 8'(bus.cmd_tag);
  assign addr_aligned = {bus.cmd_addr[31:2], 2'b00};
  assign seq_d        = seq_q + 8'd1;
  assign cnt_d        = cnt_q + 16'd1;
  // The issued {seq, tag} key stays in rd_req_ctx_q until the next read is accepted.
  assign rsp_match    = bus.rd_rsp_valid && (bus.rd_rsp_ctx[15:0] == rd_req_ctx_q[15:0]);
  assign timeout_hit  = (state_q == RD_WAIT) && !rsp_match && (cnt_q == TO_LAST);
  assign unused_bits  = ^{bus.cmd_addr[1:0], bus.rd_rsp_ctx[87:16]};

  assign bus.cmd_ready    = (state_q == IDLE) && !rst;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_be        = wr_be_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.wr_valid     = wr_valid_q;
  assign bus.rd_req_ctx   = rd_req_ctx_q;
  assign bus.rd_req_addr  = rd_req_addr_q;
  assign bus.rd_req_valid = rd_req_valid_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_tag      = res_tag_q;
  assign bus.res_err      = res_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      seq_q          <= 8'h00;
      cnt_q          <= 16'h0000;
      tag_q          <= '0;
      wr_addr_q      <= 32'h0;
      wr_be_q        <= 4'h0;
      wr_data_q      <= 32'h0;
      wr_valid_q     <= 1'b0;
      rd_req_ctx_q   <= 88'h0;
      rd_req_addr_q  <= 32'h0;
      rd_req_valid_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= 32'h0;
      res_tag_q      <= '0;
      res_err_q      <= 1'b0;
    end else begin
      wr_valid_q     <= 1'b0;
      rd_req_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            tag_q <= bus.cmd_tag;
            if (bus.cmd_we) begin
              wr_addr_q  <= addr_aligned;
              wr_be_q    <= bus.cmd_be;
              wr_data_q  <= bus.cmd_wdata;
              wr_valid_q <= 1'b1;
              state_q    <= WR;
            end else begin
              rd_req_addr_q  <= addr_aligned;
              rd_req_ctx_q   <= {72'h0, seq_q, tag8};
              rd_req_valid_q <= 1'b1;
              state_q        <= RD_REQ;
            end
          end
        end
        WR: state_q <= IDLE;
        RD_REQ: begin
          cnt_q   <= 16'h0000;
          seq_q   <= seq_d;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          cnt_q <= cnt_d;
          // A reply arriving on the timeout cycle still counts as good data.
          if (rsp_match) begin
            res_data_q  <= bus.rd_rsp_data;
            res_err_q   <= 1'b0;
            res_tag_q   <= tag_q;
            res_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            res_data_q  <= 32'hFFFF_FFFF;
            res_err_q   <= 1'b1;
            res_tag_q   <= tag_q;
            res_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BAR_RD_INITIATOR_STATS_EN
  logic rsp_dropped;
  assign rsp_dropped = bus.rd_rsp_valid && !((state_q == RD_WAIT) && rsp_match);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt      <= 32'h0;
      stat_wr_cnt      <= 32'h0;
      stat_timeout_cnt <= 16'h0;
      stat_drop_cnt    <= 16'h0;
    end else begin
      if (rd_req_valid_q) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (wr_valid_q)     stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (timeout_hit && stat_timeout_cnt != 16'hFFFF)
        stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
      if (rsp_dropped && stat_drop_cnt != 16'hFFFF)
        stat_drop_cnt <= stat_drop_cnt + 16'd1;
    end
  end
`endif
endmodule
